// File: rtl/rpm_pid_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rpm_pid_scheduler
//
// Sits between the per-motor RPM readers and the shared 3p3z PID core. Each
// channel latches its most recent RPM sample. The sample is then paired with
// that channel's target RPM and offered to the PID core one at a time over a
// valid/ready handshake. A round-robin arbiter picks the next channel.
//
// Parameters
//   NUM_CHN     number of motor channels (>= 1)
//   DATA_WIDTH  RPM / target sample width
//   CHN_WIDTH   derived channel index width (not overridable)
//
// Ports
//   clk, rst       system clock (rising edge), async active-high reset
//   rpm_valid_i    one-cycle sample strobe per channel
//   rpm_data_i     flattened samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   chn_en_i       channel enable mask
//   tgt_wr_i       target RPM write strobe (tgt_chn_i / tgt_data_i)
//   data_valid_o   sample offered to the PID core
//   data_chn_o     channel of the offered sample
//   data_fdb_o     measured RPM (feedback)
//   data_ref_o     target RPM (reference)
//   tready_i       PID core accepts the offered sample
//   ovf_o          sticky per-channel overrun flags
//   ovf_clr_i      clears all overrun flags
// -----------------------------------------------------------------------------
module rpm_pid_scheduler #(
  parameter  int NUM_CHN    = 4,
  parameter  int DATA_WIDTH = 16,
  localparam int CHN_WIDTH  = (NUM_CHN == 1) ? 1 : $clog2(NUM_CHN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHN-1:0]            rpm_valid_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
  input  logic [NUM_CHN-1:0]            chn_en_i,
  input  logic                          tgt_wr_i,
  input  logic [CHN_WIDTH-1:0]          tgt_chn_i,
  input  logic [DATA_WIDTH-1:0]         tgt_data_i,
  output logic                          data_valid_o,
  output logic [CHN_WIDTH-1:0]          data_chn_o,
  output logic [DATA_WIDTH-1:0]         data_fdb_o,
  output logic [DATA_WIDTH-1:0]         data_ref_o,
  input  logic                          tready_i,
  output logic [NUM_CHN-1:0]            ovf_o,
  input  logic                          ovf_clr_i
);

  // Per-channel state
  logic [DATA_WIDTH-1:0] r_hold [NUM_CHN];
  logic [DATA_WIDTH-1:0] r_tgt  [NUM_CHN];
  logic [NUM_CHN-1:0]    r_pend;
  logic [NUM_CHN-1:0]    r_ovf;

  // Arbiter and output register
  logic [CHN_WIDTH-1:0]  r_rr_ptr;
  logic                  r_valid;
  logic [CHN_WIDTH-1:0]  r_chn;
  logic [DATA_WIDTH-1:0] r_fdb;
  logic [DATA_WIDTH-1:0] r_ref;

  logic                  w_free;
  logic [NUM_CHN-1:0]    w_elig;
  logic [NUM_CHN-1:0]    w_cap;
  logic [NUM_CHN-1:0]    w_ld;
  logic [NUM_CHN-1:0]    w_tgt_we;
  logic                  w_hi_any;
  logic                  w_lo_any;
  logic [CHN_WIDTH-1:0]  w_hi_grant;
  logic [CHN_WIDTH-1:0]  w_lo_grant;
  logic                  w_any;
  logic [CHN_WIDTH-1:0]  w_grant;

  assign w_free = !r_valid || tready_i;
  // A disabled channel drops out of arbitration on the very edge it goes low,
  // even though its pend bit is only cleared by that edge.
  assign w_elig = r_pend & chn_en_i;
  assign w_cap  = rpm_valid_i & chn_en_i;

  // Round-robin: channels above r_rr_ptr beat channels at or below it, and
  // within each group the lowest index wins. This is the same as scanning
  // upward from r_rr_ptr+1 with wrap-around.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_hi_any   = 1'b0;
    w_lo_any   = 1'b0;
    w_hi_grant = '0;
    w_lo_grant = '0;
    for (int k = NUM_CHN - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        if (CHN_WIDTH'(k) > r_rr_ptr) begin
          w_hi_any   = 1'b1;
          w_hi_grant = CHN_WIDTH'(k);
        end else begin
          w_lo_any   = 1'b1;
          w_lo_grant = CHN_WIDTH'(k);
        end
      end
    end
    w_any   = w_hi_any || w_lo_any;
    w_grant = w_hi_any ? w_hi_grant : w_lo_grant;
  end

  // Per-channel load and target-write decodes. The equality against k < NUM_CHN
  // also drops target writes to channel indices that do not exist.
  always_comb begin
    w_ld     = '0;
    w_tgt_we = '0;
    for (int k = 0; k < NUM_CHN; k++) begin
      w_ld[k]     = w_free && w_any && (w_grant == CHN_WIDTH'(k));
      w_tgt_we[k] = tgt_wr_i && (tgt_chn_i == CHN_WIDTH'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees pre-edge values. This gives the output the old
  // hold/target on a same-edge capture or target write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_ovf    <= '0;
      r_rr_ptr <= CHN_WIDTH'(NUM_CHN - 1);
      r_valid  <= 1'b0;
      r_chn    <= '0;
      r_fdb    <= '0;
      r_ref    <= '0;
      // NOTE: the hold and target arrays are reset on purpose. A channel that
      // never received a target write must present a reference of zero.
      for (int k = 0; k < NUM_CHN; k++) begin
        r_hold[k] <= '0;
        r_tgt[k]  <= '0;
      end
    end else begin
      if (w_free) begin
        r_valid <= w_any;
        if (w_any) begin
          r_chn    <= w_grant;
          r_fdb    <= r_hold[w_grant];
          r_ref    <= r_tgt[w_grant];
          r_rr_ptr <= w_grant;
        end
      end

      for (int k = 0; k < NUM_CHN; k++) begin
        // A capture on the edge that loads the channel keeps pend set: the
        // output takes the old sample and the new one waits its turn.
        if (!chn_en_i[k]) begin
          r_pend[k] <= 1'b0;
        end else if (w_cap[k]) begin
          r_pend[k] <= 1'b1;
        end else if (w_ld[k]) begin
          r_pend[k] <= 1'b0;
        end

        if (w_cap[k]) begin
          r_hold[k] <= rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end

        if (w_tgt_we[k]) begin
          r_tgt[k] <= tgt_data_i;
        end

        // Setting a flag takes priority over a simultaneous global clear.
        if (w_cap[k] && r_pend[k] && !w_ld[k]) begin
          r_ovf[k] <= 1'b1;
        end else if (ovf_clr_i) begin
          r_ovf[k] <= 1'b0;
        end
      end
    end
  end

  assign data_valid_o = r_valid;
  assign data_chn_o   = r_chn;
  assign data_fdb_o   = r_fdb;
  assign data_ref_o   = r_ref;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_rpm_pid_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rpm_pid_scheduler
//
// Self-checking bench for rpm_pid_scheduler. The main instance has four
// channels. A three-channel instance exercises out-of-range target writes and
// round-robin wrap with a non-power-of-two channel count.
// -----------------------------------------------------------------------------
module tb_rpm_pid_scheduler;

  localparam int NC = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     rpm_valid;
  logic [NC*DW-1:0]  rpm_data;
  logic [NC-1:0]     chn_en;
  logic              tgt_wr;
  logic [1:0]        tgt_chn;
  logic [DW-1:0]     tgt_data;
  logic              data_valid;
  logic [1:0]        data_chn;
  logic [DW-1:0]     data_fdb;
  logic [DW-1:0]     data_ref;
  logic              tready;
  logic [NC-1:0]     ovf;
  logic              ovf_clr;

  logic [2:0]        d3_rpm_valid;
  logic [3*DW-1:0]   d3_rpm_data;
  logic              d3_tgt_wr;
  logic [1:0]        d3_tgt_chn;
  logic [DW-1:0]     d3_tgt_data;
  logic              d3_valid;
  logic [1:0]        d3_chn;
  logic [DW-1:0]     d3_fdb;
  logic [DW-1:0]     d3_ref;
  logic [2:0]        d3_ovf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rpm_pid_scheduler #(.NUM_CHN(NC), .DATA_WIDTH(DW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .rpm_valid_i  (rpm_valid),
    .rpm_data_i   (rpm_data),
    .chn_en_i     (chn_en),
    .tgt_wr_i     (tgt_wr),
    .tgt_chn_i    (tgt_chn),
    .tgt_data_i   (tgt_data),
    .data_valid_o (data_valid),
    .data_chn_o   (data_chn),
    .data_fdb_o   (data_fdb),
    .data_ref_o   (data_ref),
    .tready_i     (tready),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr)
  );

  rpm_pid_scheduler #(.NUM_CHN(3), .DATA_WIDTH(DW)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .rpm_valid_i  (d3_rpm_valid),
    .rpm_data_i   (d3_rpm_data),
    .chn_en_i     (3'b111),
    .tgt_wr_i     (d3_tgt_wr),
    .tgt_chn_i    (d3_tgt_chn),
    .tgt_data_i   (d3_tgt_data),
    .data_valid_o (d3_valid),
    .data_chn_o   (d3_chn),
    .data_fdb_o   (d3_fdb),
    .data_ref_o   (d3_ref),
    .tready_i     (1'b1),
    .ovf_o        (d3_ovf),
    .ovf_clr_i    (1'b0)
  );

  typedef struct {
    logic          rst_first;
    logic [3:0]    vld;
    logic [63:0]   dat;
    logic          tw;
    logic [1:0]    tc;
    logic [15:0]   td;
    logic          e_valid;
    logic [1:0]    e_chn;
    logic [15:0]   e_fdb;
    logic [15:0]   e_ref;
    logic [3:0]    e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] vld, logic [63:0] dat,
                              logic tw, logic [1:0] tc, logic [15:0] td,
                              logic ev, logic [1:0] ec, logic [15:0] ef,
                              logic [15:0] er, logic [3:0] eo);
    vec_t v;
    v.rst_first = r;  v.vld = vld; v.dat = dat;
    v.tw = tw;        v.tc = tc;   v.td = td;
    v.e_valid = ev;   v.e_chn = ec; v.e_fdb = ef; v.e_ref = er; v.e_ovf = eo;
    return v;
  endfunction

  function automatic logic [63:0] pack(logic v, logic [1:0] c, logic [15:0] f,
                                       logic [15:0] r, logic [3:0] o);
    return {25'd0, v, c, f, r, o};
  endfunction

  function automatic logic [63:0] snap();
    return pack(data_valid, data_chn, data_fdb, data_ref, ovf);
  endfunction

  function automatic logic [63:0] snap3();
    return pack(d3_valid, d3_chn, d3_fdb, d3_ref, {1'b0, d3_ovf});
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Outputs are sampled and inputs changed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] vld, input logic [63:0] dat,
                       input logic clr);
    rpm_valid = vld;
    rpm_data  = dat;
    ovf_clr   = clr;
    tick();
    rpm_valid = '0;
    ovf_clr   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rpm_valid = '0; rpm_data = '0; chn_en = 4'hF;
    tgt_wr = 1'b0; tgt_chn = '0; tgt_data = '0;
    tready = 1'b0; ovf_clr = 1'b0;
    d3_rpm_valid = '0; d3_rpm_data = '0;
    d3_tgt_wr = 1'b0; d3_tgt_chn = '0; d3_tgt_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_state", snap(), '0);

    // Asynchronous reset mid-transfer: ch0 in the output, ch1 still pending.
    drive(4'b0011, 64'h0000_0000_000B_000A, 1'b0);
    drive(4'b0000, '0, 1'b0);
    check("pre_rst_load", snap(), pack(1'b1, 2'd0, 16'h000A, 16'h0, 4'h0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", snap(), '0);
    #2;
    rst = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_after_rst%0d", i), {63'd0, data_valid}, 64'd0);
    end

    // Table: simultaneous strobes, single-channel path, same-edge target
    // write, and fairness against a frequently strobed channel.
    tbl.push_back(mk(1, 4'hF, 64'h0044_0033_0022_0011, 0, 0, 0,      0, 0, 16'h0,    16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 0, 16'h0011, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 1, 16'h0022, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 2, 16'h0033, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 3, 16'h0044, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      0, 3, 16'h0044, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       1, 2, 16'd1000, 0, 3, 16'h0044, 16'h0,  0));
    tbl.push_back(mk(0, 4'h4, 64'h0000_0123_0000_0000, 0, 0, 0,      0, 3, 16'h0044, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 2, 16'h0123, 16'd1000, 0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      0, 2, 16'h0123, 16'd1000, 0));
    tbl.push_back(mk(0, 4'h4, 64'h0000_0456_0000_0000, 0, 0, 0,      0, 2, 16'h0123, 16'd1000, 0));
    tbl.push_back(mk(0, 4'h0, 0,                       1, 2, 16'h0777, 1, 2, 16'h0456, 16'd1000, 0));
    tbl.push_back(mk(0, 4'h4, 64'h0000_0789_0000_0000, 0, 0, 0,      0, 2, 16'h0456, 16'd1000, 0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 2, 16'h0789, 16'h0777, 0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      0, 2, 16'h0789, 16'h0777, 0));
    // Fairness: ch3 strobed once, ch0 on every other edge so it never overruns.
    tbl.push_back(mk(1, 4'h9, 64'h03AA_0000_0000_0201, 0, 0, 0,      0, 0, 16'h0,    16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 0, 16'h0201, 16'h0,    0));
    tbl.push_back(mk(0, 4'h1, 64'h0000_0000_0000_0203, 0, 0, 0,      1, 3, 16'h03AA, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 0, 16'h0203, 16'h0,    0));
    tbl.push_back(mk(0, 4'h1, 64'h0000_0000_0000_0205, 0, 0, 0,      0, 0, 16'h0203, 16'h0,    0));
    tbl.push_back(mk(0, 4'h0, 0,                       0, 0, 0,      1, 0, 16'h0205, 16'h0,    0));

    tready = 1'b1;
    chn_en = 4'hF;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      tgt_wr   = tbl[i].tw;
      tgt_chn  = tbl[i].tc;
      tgt_data = tbl[i].td;
      drive(tbl[i].vld, tbl[i].dat, 1'b0);
      tgt_wr = 1'b0;
      check($sformatf("vec%0d", i), snap(),
            pack(tbl[i].e_valid, tbl[i].e_chn, tbl[i].e_fdb, tbl[i].e_ref, tbl[i].e_ovf));
    end

    // Backpressure and overrun: ch0 parked in the output, ch1 overruns,
    // then a clear collides with a fresh overrun on ch2.
    do_reset();
    tready = 1'b0;
    drive(4'b0001, 64'h0000_0000_0000_00A0, 1'b0);
    check("bp_idle", snap(), '0);
    drive(4'b0000, '0, 1'b0);
    check("bp_load", snap(), pack(1, 0, 16'h00A0, 0, 4'h0));
    drive(4'b0010, 64'h0000_0000_0010_0000, 1'b0);
    check("bp_stable0", snap(), pack(1, 0, 16'h00A0, 0, 4'h0));
    drive(4'b0000, '0, 1'b0);
    check("bp_stable1", snap(), pack(1, 0, 16'h00A0, 0, 4'h0));
    drive(4'b0000, '0, 1'b0);
    check("bp_stable2", snap(), pack(1, 0, 16'h00A0, 0, 4'h0));
    drive(4'b0010, 64'h0000_0000_0020_0000, 1'b0);
    check("bp_ovf1", snap(), pack(1, 0, 16'h00A0, 0, 4'b0010));
    drive(4'b0100, 64'h0000_0030_0000_0000, 1'b0);
    check("bp_pend2", snap(), pack(1, 0, 16'h00A0, 0, 4'b0010));
    drive(4'b0100, 64'h0000_0031_0000_0000, 1'b1);
    check("bp_clr_vs_set", snap(), pack(1, 0, 16'h00A0, 0, 4'b0100));
    tready = 1'b1;
    drive(4'b0000, '0, 1'b0);
    check("bp_ch1_newest", snap(), pack(1, 1, 16'h0020, 0, 4'b0100));
    drive(4'b0000, '0, 1'b0);
    check("bp_ch2_newest", snap(), pack(1, 2, 16'h0031, 0, 4'b0100));
    drive(4'b0000, '0, 1'b0);
    check("bp_drained", snap(), pack(0, 2, 16'h0031, 0, 4'b0100));
    drive(4'b0000, '0, 1'b1);
    check("bp_ovf_clr", snap(), pack(0, 2, 16'h0031, 0, 4'h0));

    // Enable mask: an issued sample completes, a pending one is dropped,
    // and strobes on a disabled channel are ignored.
    do_reset();
    tready = 1'b0;
    drive(4'b0011, 64'h0000_0000_0061_0060, 1'b0);
    check("en_capture", snap(), '0);
    drive(4'b0000, '0, 1'b0);
    check("en_load", snap(), pack(1, 0, 16'h0060, 0, 4'h0));
    chn_en = 4'b1100;
    drive(4'b0000, '0, 1'b0);
    check("en_out_completes", snap(), pack(1, 0, 16'h0060, 0, 4'h0));
    chn_en = 4'hF;
    tready = 1'b1;
    drive(4'b0000, '0, 1'b0);
    check("en_pend_dropped", snap(), pack(0, 0, 16'h0060, 0, 4'h0));
    chn_en = 4'b1101;
    drive(4'b0010, 64'h0000_0000_0055_0000, 1'b0);
    check("en_strobe_ign0", snap(), pack(0, 0, 16'h0060, 0, 4'h0));
    drive(4'b0000, '0, 1'b0);
    check("en_strobe_ign1", snap(), pack(0, 0, 16'h0060, 0, 4'h0));
    drive(4'b0000, '0, 1'b0);
    check("en_strobe_ign2", snap(), pack(0, 0, 16'h0060, 0, 4'h0));
    chn_en = 4'hF;

    // Same-edge load and capture on ch2.
    do_reset();
    drive(4'b0100, 64'h0000_00C1_0000_0000, 1'b0);
    check("same_edge_cap", snap(), '0);
    drive(4'b0100, 64'h0000_00C2_0000_0000, 1'b0);
    check("same_edge_old", snap(), pack(1, 2, 16'h00C1, 0, 4'h0));
    drive(4'b0000, '0, 1'b0);
    check("same_edge_new", snap(), pack(1, 2, 16'h00C2, 0, 4'h0));
    drive(4'b0000, '0, 1'b0);
    check("same_edge_done", snap(), pack(0, 2, 16'h00C2, 0, 4'h0));

    // Three-channel instance: target write to index 3 is ignored, and the
    // round-robin pointer wraps from channel 2 back to channel 0.
    do_reset();
    d3_tgt_wr = 1'b1; d3_tgt_chn = 2'd0; d3_tgt_data = 16'h00AA;
    tick();
    d3_tgt_chn = 2'd3; d3_tgt_data = 16'h00BB;
    tick();
    d3_tgt_wr = 1'b0;
    d3_rpm_valid = 3'b101; d3_rpm_data = {16'h0002, 16'h0000, 16'h0001};
    tick();
    d3_rpm_valid = '0;
    check("d3_capture", snap3(), '0);
    tick();
    check("d3_ch0_ref", snap3(), pack(1, 0, 16'h0001, 16'h00AA, 4'h0));
    tick();
    check("d3_oor_tgt", snap3(), pack(1, 2, 16'h0002, 16'h0000, 4'h0));
    d3_rpm_valid = 3'b011; d3_rpm_data = {16'h0000, 16'h0004, 16'h0003};
    tick();
    d3_rpm_valid = '0;
    check("d3_drain", snap3(), pack(0, 2, 16'h0002, 16'h0000, 4'h0));
    tick();
    check("d3_wrap", snap3(), pack(1, 0, 16'h0003, 16'h00AA, 4'h0));
    tick();
    check("d3_next", snap3(), pack(1, 1, 16'h0004, 16'h0000, 4'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
